// File: rtl/seq_div_hs.sv
// Sequential restoring divider with valid/ready handshakes on operands and result.
// Define SEQ_DIV_SIGNED_EN to honour sgn (two's-complement operands); otherwise all unsigned.
module seq_div_hs #(
  parameter int WIDTH  = 24,
  parameter int QWIDTH = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sgn,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [WIDTH-1:0]  divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QWIDTH-1:0] quo,
  output logic [WIDTH-1:0]  rem,
  output logic              dbz,
  output logic              ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ULIM = {{WIDTH{1'b0}}, 1'b1} << QWIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]  acc_q, rmd_q, dvs_q;
  logic [CW-1:0]     cnt_q;
  logic              zero_q, negq_q, negr_q;
  logic              accept, neg_a, neg_b, ovf_c;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    trial;

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [WIDTH:0] SLIM = {{WIDTH{1'b0}}, 1'b1} << (QWIDTH - 1);
  logic sgn_q;
  assign neg_a = sgn & dividend[WIDTH-1];
  assign neg_b = sgn & divisor[WIDTH-1];
  // Negative results may reach -2^(QWIDTH-1); positive ones stop one short.
  assign ovf_c = !sgn_q ? ({1'b0, acc_q} >= ULIM) :
                 negq_q ? ({1'b0, acc_q} > SLIM) : ({1'b0, acc_q} >= SLIM);
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
  assign ovf_c = ({1'b0, acc_q} >= ULIM);
`endif

  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor  : divisor;
  assign trial = {rmd_q, acc_q[WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = (divisor == '0) ? FIX : CALC;
      end
      CALC: if (cnt_q == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q  <= '0;
      rmd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          zero_q <= (divisor == '0);
          // Divide-by-zero keeps the raw dividend so it can be returned as rem.
          acc_q  <= (divisor == '0) ? dividend : mag_a;
          dvs_q  <= mag_b;
          rmd_q  <= '0;
          cnt_q  <= CW'(WIDTH);
          negq_q <= neg_a ^ neg_b;
          negr_q <= neg_a;
`ifdef SEQ_DIV_SIGNED_EN
          sgn_q  <= sgn;
`endif
        end
        CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (!trial[WIDTH]) begin
            rmd_q <= trial[WIDTH-1:0];
            acc_q <= {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rmd_q <= {rmd_q[WIDTH-2:0], acc_q[WIDTH-1]};
            acc_q <= {acc_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (zero_q) begin
            quo <= '1;
            rem <= acc_q;
            dbz <= 1'b1;
            ovf <= 1'b0;
          end else begin
            quo <= negq_q ? -acc_q[QWIDTH-1:0] : acc_q[QWIDTH-1:0];
            rem <= negr_q ? -rmd_q : rmd_q;
            dbz <= 1'b0;
            ovf <= ovf_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_hs.sv
// Directed bench for seq_div_hs (WIDTH=24, QWIDTH=8); signed cases follow SEQ_DIV_SIGNED_EN.
module tb_seq_div_hs;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0, in_ready, sgn = 1'b0;
  logic [23:0] dividend = '0, divisor = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [7:0]  quo;
  logic [23:0] rem;
  logic        dbz, ovf;
  int          total = 0, bad = 0;
  int          lat, seen;

  seq_div_hs #(.WIDTH(24), .QWIDTH(8)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .sgn(sgn),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then scramble them and count edges to out_valid.
  task automatic start_op(input logic [23:0] a, input logic [23:0] b, input logic s);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    dividend = a; divisor = b; sgn = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = 24'hABCDEF; divisor = 24'h000001; sgn = ~s;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic check_res(input string tag, input int exp_lat, input logic [7:0] q,
                           input logic [23:0] r, input logic z, input logic o);
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_quo"}, 32'(quo), 32'(q));
    chk({tag, "_rem"}, 32'(rem), 32'(r));
    chk({tag, "_dbz"}, 32'(dbz), 32'(z));
    chk({tag, "_ovf"}, 32'(ovf), 32'(o));
  endtask

  task automatic release_res();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {quo, rem}, 32'd0);
    chk("rst_flags", {dbz, ovf}, 32'd0);
    @(negedge clk); nrst = 1'b1;

    start_op(24'd1000, 24'd7, 1'b0);
    check_res("u1000_7", 25, 8'd142, 24'd6, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quo_rem", {quo, rem}, {8'd142, 24'd6});
      chk("hold_flags", {dbz, ovf}, 32'd0);
    end
    release_res();

    start_op(24'd100000, 24'd3, 1'b0);
    check_res("u100000_3", 25, 8'h35, 24'd1, 1'b0, 1'b1);
    release_res();

    start_op(24'd5, 24'd0, 1'b0);
    check_res("dbz_5_0", 1, 8'hFF, 24'd5, 1'b1, 1'b0);
    release_res();

    start_op(24'd255, 24'd1, 1'b0);
    check_res("u255_1", 25, 8'hFF, 24'd0, 1'b0, 1'b0);
    release_res();

    start_op(24'd256, 24'd1, 1'b0);
    check_res("u256_1", 25, 8'h00, 24'd0, 1'b0, 1'b1);
    release_res();

`ifdef SEQ_DIV_SIGNED_EN
    start_op(24'hFFFFF9, 24'd2, 1'b1);
    check_res("s_m7_2", 25, 8'hFD, 24'hFFFFFF, 1'b0, 1'b0);
    release_res();
    start_op(24'd7, 24'hFFFFFE, 1'b1);
    check_res("s_7_m2", 25, 8'hFD, 24'd1, 1'b0, 1'b0);
    release_res();
    start_op(24'h800000, 24'hFFFFFF, 1'b1);
    check_res("s_min_m1", 25, 8'h00, 24'd0, 1'b0, 1'b1);
    release_res();
    start_op(24'hFFFF80, 24'd1, 1'b1);
    check_res("s_m128_1", 25, 8'h80, 24'd0, 1'b0, 1'b0);
    release_res();
`else
    start_op(24'hFFFFF9, 24'd2, 1'b1);
    check_res("u_sgn_ignored", 25, 8'hFC, 24'd1, 1'b0, 1'b1);
    release_res();
`endif

    start_op(24'd1000, 24'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_outputs", {quo, rem}, 32'd0);
    @(negedge clk); nrst = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    start_op(24'd9, 24'd3, 1'b0);
    check_res("u9_3", 25, 8'd3, 24'd0, 1'b0, 1'b0);
    release_res();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
